mem_req_ctrl: RTL and testbench

- Initiator-side controller for the stalling 16-bit byte-addressed data/instruction memory.
- Accepts one load/store request at a time from a pipeline stage and drives Addr/DataIn/Rd/Wr to the memory.
- Holds Rd/Wr until the memory returns Done, then returns the read data or completion to the pipeline.
- Detects misaligned addresses locally, enforces a timeout on lost requests, and counts stall cycles for performance reporting.

---
 rtl/mem_req_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_req_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_ctrl
// Purpose  : single-outstanding load/store initiator for the stalling memory
// Revision : 1.0
// ============================================================================
module mem_req_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_wr,
  input  logic [15:0]      req_addr,
  input  logic [15:0]      req_wdata,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [15:0]      resp_rdata,
  output logic             resp_err,
  output logic             resp_timeout,
  output logic             pipe_stall,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_done,
  input  logic             mem_stall,
  input  logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Last counter value before the timeout edge: the edge that would take the
  // counter to TIMEOUT-1 abandons the request.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 2);
  localparam logic [15:0] TMO_ONE  = 16'd1;
  localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic [15:0]      tmo_q, tmo_d;
  logic             rvalid_q, rvalid_d;
  logic             rerr_q, rerr_d;
  logic             rto_q, rto_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= 16'h0;
      wdata_q  <= 16'h0;
      wr_q     <= 1'b0;
      tmo_q    <= 16'h0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rto_q    <= 1'b0;
      rdata_q  <= 16'h0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      tmo_q    <= tmo_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rto_q    <= rto_d;
      rdata_q  <= rdata_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    tmo_d    = tmo_q;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    rto_d    = 1'b0;
    rdata_d  = 16'h0;
    stall_d  = (mem_stall && (stall_q != '1)) ? stall_q + STALL_ONE : stall_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          // Odd addresses are rejected locally without touching the memory.
          if (req_addr[0]) begin
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
          end else begin
            state_d = BUSY;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            wr_d    = req_wr;
            tmo_d   = 16'h0;
          end
        end
      end
      BUSY: begin
        if (mem_done) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rerr_d   = mem_err;
          rdata_d  = wr_q ? 16'h0 : mem_rdata;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
          if (tmo_q == TMO_LAST) begin
            state_d  = IDLE;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            rto_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == IDLE);
    pipe_stall   = (state_q == BUSY);
    mem_rd       = (state_q == BUSY) && !wr_q;
    mem_wr       = (state_q == BUSY) && wr_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    resp_valid   = rvalid_q;
    resp_err     = rerr_q;
    resp_timeout = rto_q;
    resp_rdata   = rdata_q;
    stall_cycles = stall_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
`default_nettype none
// Bench for mem_req_ctrl: instance A (defaults) is tracked by a cycle-level
// reference model; instance B (TIMEOUT=4, CNT_W=4) covers timeout and saturation.
module tb_mem_req_ctrl;

  localparam int TMO_A = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A
  logic        req_valid_a = 1'b0, req_wr_a = 1'b0;
  logic [15:0] req_addr_a = 16'h0, req_wdata_a = 16'h0;
  logic        req_ready_a, resp_valid_a, resp_err_a, resp_timeout_a, pipe_stall_a;
  logic        mem_rd_a, mem_wr_a;
  logic [15:0] resp_rdata_a, mem_addr_a, mem_wdata_a;
  logic [15:0] mem_rdata_a = 16'hDEAD;
  logic        mem_done_a = 1'b0, mem_stall_a = 1'b0, mem_err_a = 1'b0;
  logic [15:0] stall_cycles_a;

  // Instance B
  logic        req_valid_b = 1'b0;
  logic [15:0] req_addr_b = 16'h0;
  logic        req_ready_b, resp_valid_b, resp_err_b, resp_timeout_b, pipe_stall_b;
  logic        mem_rd_b, mem_wr_b;
  logic [15:0] resp_rdata_b, mem_addr_b, mem_wdata_b;
  logic        mem_stall_b = 1'b0;
  logic [3:0]  stall_cycles_b;

  mem_req_ctrl #(.TIMEOUT(TMO_A), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_wr(req_wr_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .req_ready(req_ready_a), .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a),
    .resp_err(resp_err_a), .resp_timeout(resp_timeout_a), .pipe_stall(pipe_stall_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rd(mem_rd_a), .mem_wr(mem_wr_a),
    .mem_rdata(mem_rdata_a), .mem_done(mem_done_a), .mem_stall(mem_stall_a), .mem_err(mem_err_a),
    .stall_cycles(stall_cycles_a)
  );

  mem_req_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_wr(1'b0), .req_addr(req_addr_b), .req_wdata(16'h0),
    .req_ready(req_ready_b), .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
    .resp_err(resp_err_b), .resp_timeout(resp_timeout_b), .pipe_stall(pipe_stall_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b),
    .mem_rdata(16'h0), .mem_done(1'b0), .mem_stall(mem_stall_b), .mem_err(1'b0),
    .stall_cycles(stall_cycles_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder for A: raises Done after rsp_delay stalled BUSY cycles.
  logic [15:0] mem [0:32767];
  int   rsp_delay = 0;
  int   rsp_cnt   = 0;
  logic err_force = 1'b0;

  always @(negedge clk) begin
    if (mem_rd_a || mem_wr_a) begin
      if (rsp_cnt >= rsp_delay) begin
        mem_done_a  = 1'b1;
        mem_stall_a = 1'b0;
        mem_err_a   = err_force;
        if (mem_rd_a) mem_rdata_a = mem[mem_addr_a[15:1]];
        else begin
          mem_rdata_a = 16'hFFFF;
          mem[mem_addr_a[15:1]] = mem_wdata_a;
        end
        rsp_cnt = 0;
      end else begin
        mem_done_a  = 1'b0;
        mem_stall_a = 1'b1;
        mem_err_a   = 1'b0;
        mem_rdata_a = 16'hDEAD;
        rsp_cnt++;
      end
    end else begin
      mem_done_a  = 1'b0;
      mem_stall_a = 1'b0;
      mem_err_a   = 1'b0;
      mem_rdata_a = 16'hDEAD;
      rsp_cnt     = 0;
    end
  end

  // Reference model for A: one outstanding request with an age in cycles.
  bit          started = 1'b0;
  bit          m_busy, m_wr, e_rv, e_err, e_to;
  int          m_age, e_stalls;
  logic [15:0] m_addr, m_wdata, e_rdata;

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      m_busy = 1'b0; m_wr = 1'b0; m_age = 0; e_stalls = 0;
      m_addr = 16'h0; m_wdata = 16'h0;
      e_rv = 1'b0; e_err = 1'b0; e_to = 1'b0; e_rdata = 16'h0;
    end else begin
      e_rv = 1'b0; e_err = 1'b0; e_to = 1'b0; e_rdata = 16'h0;
      if (mem_stall_a && e_stalls < 65535) e_stalls++;
      if (!m_busy) begin
        if (req_valid_a) begin
          if (req_addr_a[0]) begin
            e_rv = 1'b1; e_err = 1'b1;
          end else begin
            m_busy = 1'b1; m_age = 0;
            m_wr = req_wr_a; m_addr = req_addr_a; m_wdata = req_wdata_a;
          end
        end
      end else if (mem_done_a) begin
        m_busy = 1'b0; e_rv = 1'b1; e_err = mem_err_a;
        e_rdata = m_wr ? 16'h0 : mem_rdata_a;
      end else begin
        m_age++;
        if (m_age >= TMO_A - 1) begin
          m_busy = 1'b0; e_rv = 1'b1; e_err = 1'b1; e_to = 1'b1;
        end
      end
    end
    #1;
    if (started) begin
      chk("req_ready",    32'(req_ready_a),    32'(!m_busy));
      chk("pipe_stall",   32'(pipe_stall_a),   32'(m_busy));
      chk("mem_rd",       32'(mem_rd_a),       32'(m_busy && !m_wr));
      chk("mem_wr",       32'(mem_wr_a),       32'(m_busy && m_wr));
      chk("mem_addr",     32'(mem_addr_a),     32'(m_addr));
      chk("mem_wdata",    32'(mem_wdata_a),    32'(m_wdata));
      chk("resp_valid",   32'(resp_valid_a),   32'(e_rv));
      chk("resp_err",     32'(resp_err_a),     32'(e_err));
      chk("resp_timeout", 32'(resp_timeout_a), 32'(e_to));
      chk("resp_rdata",   32'(resp_rdata_a),   32'(e_rdata));
      chk("stall_cycles", 32'(stall_cycles_a), 32'(e_stalls));
    end
  end

  // Issue one request on A and collect its response.
  task automatic req_a(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                       input int delay, output int lat, output int acc,
                       output logic [15:0] rdata, output logic err, output logic to);
    bit got;
    @(negedge clk);
    rsp_delay = delay;
    req_valid_a = 1'b1; req_wr_a = wr; req_addr_a = addr; req_wdata_a = wdata;
    lat = 0; acc = 0; got = 1'b0;
    rdata = 16'hxxxx; err = 1'bx; to = 1'bx;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      req_valid_a = 1'b0;
      lat++;
      if (mem_rd_a || mem_wr_a) acc++;
      if (resp_valid_a) begin
        rdata = resp_rdata_a; err = resp_err_a; to = resp_timeout_a; got = 1'b1;
        break;
      end
    end
    if (!got) chk("resp_wait_a", 32'(resp_valid_a), 32'd1);
  endtask

  int          lat, acc, busy_b, rd_b;
  logic [15:0] rdata;
  logic        err, to;
  bit          got_b;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0;
    mem[15'h0008] = 16'h1234;
    mem[15'h0018] = 16'hA5A5;
    mem[15'h0019] = 16'h5A5A;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid_a),   32'd0);
    chk("rst_mem_addr",   32'(mem_addr_a),     32'd0);
    chk("rst_stall_a",    32'(stall_cycles_a), 32'd0);
    chk("rst_req_ready",  32'(req_ready_a),    32'd1);
    chk("rst_stall_b",    32'(stall_cycles_b), 32'd0);
    rst = 1'b0;

    // Load, memory ready immediately
    req_a(1'b0, 16'h0010, 16'h0, 0, lat, acc, rdata, err, to);
    chk("ld_latency", 32'(lat),   32'd2);
    chk("ld_rd_cyc",  32'(acc),   32'd1);
    chk("ld_rdata",   32'(rdata), 32'h1234);
    chk("ld_err",     32'(err),   32'd0);

    // Store with 3 stalled cycles
    req_a(1'b1, 16'h0020, 16'hBEEF, 3, lat, acc, rdata, err, to);
    chk("st_latency", 32'(lat),            32'd5);
    chk("st_wr_cyc",  32'(acc),            32'd4);
    chk("st_err",     32'(err),            32'd0);
    chk("st_rdata",   32'(rdata),          32'd0);
    chk("st_stalls",  32'(stall_cycles_a), 32'd3);
    req_a(1'b0, 16'h0020, 16'h0, 1, lat, acc, rdata, err, to);
    chk("ld_back",    32'(rdata),          32'hBEEF);

    // Misaligned request
    req_a(1'b0, 16'h0013, 16'h0, 0, lat, acc, rdata, err, to);
    chk("mis_latency", 32'(lat), 32'd1);
    chk("mis_access",  32'(acc), 32'd0);
    chk("mis_err",     32'(err), 32'd1);
    chk("mis_to",      32'(to),  32'd0);

    // Memory-reported error
    err_force = 1'b1;
    req_a(1'b0, 16'h0010, 16'h0, 1, lat, acc, rdata, err, to);
    err_force = 1'b0;
    chk("merr_err", 32'(err), 32'd1);
    chk("merr_to",  32'(to),  32'd0);

    // Back-to-back loads, second held valid during the first
    @(negedge clk);
    rsp_delay = 0; req_valid_a = 1'b1; req_wr_a = 1'b0; req_addr_a = 16'h0030;
    @(negedge clk);
    chk("b2b_busy1", 32'(pipe_stall_a), 32'd1);
    req_addr_a = 16'h0032;
    @(negedge clk);
    chk("b2b_rv1",   32'(resp_valid_a), 32'd1);
    chk("b2b_rd1",   32'(resp_rdata_a), 32'hA5A5);
    chk("b2b_ready", 32'(req_ready_a),  32'd1);
    @(negedge clk);
    req_valid_a = 1'b0;
    chk("b2b_busy2", 32'(pipe_stall_a), 32'd1);
    @(negedge clk);
    chk("b2b_rv2",   32'(resp_valid_a), 32'd1);
    chk("b2b_rd2",   32'(resp_rdata_a), 32'h5A5A);
    @(negedge clk);
    chk("b2b_rv_off", 32'(resp_valid_a), 32'd0);

    // Timeout on B (TIMEOUT=4, Done never arrives)
    @(negedge clk);
    req_valid_b = 1'b1; req_addr_b = 16'h0040;
    lat = 0; busy_b = 0; rd_b = 0; got_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid_b = 1'b0;
      lat++;
      if (pipe_stall_b) busy_b++;
      if (mem_rd_b) rd_b++;
      if (resp_valid_b) begin
        got_b = 1'b1;
        chk("tmo_err",   32'(resp_err_b),     32'd1);
        chk("tmo_flag",  32'(resp_timeout_b), 32'd1);
        chk("tmo_rdata", 32'(resp_rdata_b),   32'd0);
        chk("tmo_ready", 32'(req_ready_b),    32'd1);
        break;
      end
    end
    if (!got_b) chk("resp_wait_b", 32'(resp_valid_b), 32'd1);
    chk("tmo_latency", 32'(lat),    32'd4);
    chk("tmo_busy",    32'(busy_b), 32'd3);
    chk("tmo_rd",      32'(rd_b),   32'd3);
    @(negedge clk);
    chk("tmo_rv_off",   32'(resp_valid_b),   32'd0);
    chk("tmo_flag_off", 32'(resp_timeout_b), 32'd0);

    // Stall counter saturation on B
    mem_stall_b = 1'b1;
    repeat (10) @(negedge clk);
    chk("sat_mid",  32'(stall_cycles_b), 32'hA);
    repeat (10) @(negedge clk);
    chk("sat_full", 32'(stall_cycles_b), 32'hF);
    mem_stall_b = 1'b0;

    // Reset while a store is outstanding on A
    @(negedge clk);
    rsp_delay = 10; req_valid_a = 1'b1; req_wr_a = 1'b1;
    req_addr_a = 16'h0040; req_wdata_a = 16'h7777;
    @(negedge clk);
    req_valid_a = 1'b0;
    chk("rb_mem_wr", 32'(mem_wr_a), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rb_mem_rd",  32'(mem_rd_a),       32'd0);
    chk("rb_mem_wr0", 32'(mem_wr_a),       32'd0);
    chk("rb_rv",      32'(resp_valid_a),   32'd0);
    chk("rb_addr",    32'(mem_addr_a),     32'd0);
    chk("rb_wdata",   32'(mem_wdata_a),    32'd0);
    chk("rb_stall",   32'(pipe_stall_a),   32'd0);
    chk("rb_cnt",     32'(stall_cycles_a), 32'd0);
    chk("rb_cnt_b",   32'(stall_cycles_b), 32'd0);
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      chk("rb_no_resp", 32'(resp_valid_a), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
